// File: rtl/decode_pipe_if.sv
// decode_pipe_pkg + decode_pipe_if
//
// Shared enums for the decode stage and the interface that bundles the
// fetch-side and execute-side handshakes plus the decoded payload.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. Valid never depends on ready.
// Once raised, the stage's out_valid_o stays up with a stable payload
// until out_ready_i takes it, unless flush or reset clears it.
//
// Modports:
//   slave  - the decode stage itself (consumes instr/pc, produces payload)
//   master - the environment (fetch + execute) around the stage
package decode_pipe_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef enum logic [2:0] {
      SRC_RS1, SRC_RS2, SRC_PC, SRC_ZERO, SRC_IMM
   } alu_src_e;

   // UNDEF is encoded as 0 so that a cleared register reads UNDEF.
   typedef enum logic [2:0] {
      UNDEF, BYTE_S, BYTE_U, HALF_S, HALF_U, WORD
   } data_size_e;
endpackage

interface decode_pipe_if #(
   parameter int PC_WIDTH = 32
);
   import decode_pipe_pkg::*;

   logic                in_valid_i;
   logic                in_ready_o;
   logic [31:0]         instr_i;
   logic [PC_WIDTH-1:0] pc_i;
   logic                flush_i;
   logic                out_ready_i;
   logic                out_valid_o;
   logic [PC_WIDTH-1:0] pc_o;
   logic [4:0]          sel_rs1_o;
   logic [4:0]          sel_rs2_o;
   logic [4:0]          sel_rd_o;
   alu_op_e             alu_op_o;
   alu_src_e            alu_src1_o;
   alu_src_e            alu_src2_o;
   logic                mem_re_o;
   logic                mem_we_o;
   data_size_e          mem_size_o;
   logic [31:0]         imm_o;
   logic                branch_o;
   logic [2:0]          br_cond_o;
   logic                jump_o;
   logic                illegal_o;

   modport slave (
      input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, sel_rs1_o, sel_rs2_o, sel_rd_o,
             alu_op_o, alu_src1_o, alu_src2_o, mem_re_o, mem_we_o,
             mem_size_o, imm_o, branch_o, br_cond_o, jump_o, illegal_o
   );

   modport master (
      output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, sel_rs1_o, sel_rs2_o, sel_rd_o,
             alu_op_o, alu_src1_o, alu_src2_o, mem_re_o, mem_we_o,
             mem_size_o, imm_o, branch_o, br_cond_o, jump_o, illegal_o
   );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe
//
// RV32I / RV32E instruction decode stage with a valid/ready handshake on
// both sides, load-use interlock, flush and illegal-instruction flagging.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - decode_pipe_if.slave: fetch side (in_valid_i/in_ready_o/instr_i/
//          pc_i), flush_i, execute side (out_valid_o/out_ready_i) and the
//          registered decode payload. sel_rs1_o/sel_rs2_o are combinational
//          from instr_i so the register file can be read in parallel.
module decode_pipe
   import decode_pipe_pkg::*;
#(
   parameter int PC_WIDTH           = 32,
   parameter int NUM_REGS           = 32,
   parameter bit LOAD_USE_INTERLOCK = 1'b1
) (
   input logic          clk,
   input logic          rst,
   decode_pipe_if.slave bus
);

   localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1_f, rs2_f, rd_f;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = bus.instr_i[6:0];
   assign funct3 = bus.instr_i[14:12];
   assign funct7 = bus.instr_i[31:25];
   assign rs1_f  = bus.instr_i[19:15];
   assign rs2_f  = bus.instr_i[24:20];
   assign rd_f   = bus.instr_i[11:7];

   assign imm_i = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
   assign imm_s = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
   assign imm_b = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                   bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
   assign imm_u = {bus.instr_i[31:12], 12'b0};
   assign imm_j = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                   bus.instr_i[20], bus.instr_i[30:21], 1'b0};

   // Integer ALU op from funct3; alt selects SUB/SRA (funct7 = 0100000).
   function automatic alu_op_e int_op(input logic [2:0] f3, input logic alt_op);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt_op ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt_op ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Load/store width from funct3; UNDEF marks an encoding that is not legal.
   function automatic data_size_e size_of(input logic [2:0] f3);
      data_size_e sz;
      case (f3)
         3'b000:  sz = BYTE_S;
         3'b001:  sz = HALF_S;
         3'b010:  sz = WORD;
         3'b100:  sz = BYTE_U;
         3'b101:  sz = HALF_U;
         default: sz = UNDEF;
      endcase
      return sz;
   endfunction

   logic       use_rs1, use_rs2, use_rd, bad_enc, alt;
   alu_op_e    d_op;
   alu_src_e   d_src1, d_src2;
   data_size_e d_size;
   logic       d_re, d_we, d_br, d_jmp, d_ill;
   logic [31:0] d_imm;
   logic [4:0] d_rs1, d_rs2, d_rd;
   logic [2:0] d_cond;

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      bad_enc = 1'b0;
      d_op    = ALU_ADD;
      d_src1  = SRC_RS1;
      d_src2  = SRC_RS2;
      d_size  = UNDEF;
      d_re    = 1'b0;
      d_we    = 1'b0;
      d_br    = 1'b0;
      d_jmp   = 1'b0;
      d_imm   = '0;
      d_cond  = '0;
      alt     = (funct7 == 7'b0100000);
      case (opcode)
         7'b0110011: begin // OP
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            d_op    = int_op(funct3, alt);
            bad_enc = !((funct7 == 7'b0) || (alt && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         7'b0010011: begin // OP-IMM
            use_rs1 = 1'b1; use_rd = 1'b1;
            d_src2  = SRC_IMM;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               // Shifts: imm is the 5-bit shamt; funct7 selects SRAI only.
               d_imm   = {27'b0, rs2_f};
               d_op    = int_op(funct3, alt && funct3 == 3'b101);
               bad_enc = !((funct7 == 7'b0) || (alt && funct3 == 3'b101));
            end else begin
               d_imm = imm_i;
               d_op  = int_op(funct3, 1'b0);
            end
         end
         7'b0000011: begin // LOAD
            use_rs1 = 1'b1; use_rd = 1'b1;
            d_src2  = SRC_IMM;
            d_imm   = imm_i;
            d_re    = 1'b1;
            d_size  = size_of(funct3);
            bad_enc = (d_size == UNDEF);
         end
         7'b0100011: begin // STORE
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_src2  = SRC_IMM;
            d_imm   = imm_s;
            d_we    = 1'b1;
            d_size  = size_of(funct3);
            bad_enc = funct3[2] || (funct3 == 3'b011);
         end
         7'b1100011: begin // BRANCH
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_br    = 1'b1;
            d_cond  = funct3;
            d_imm   = imm_b;
            d_op    = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            bad_enc = (funct3[2:1] == 2'b01);
         end
         7'b0110111: begin // LUI
            use_rd = 1'b1; d_src1 = SRC_ZERO; d_src2 = SRC_IMM; d_imm = imm_u;
         end
         7'b0010111: begin // AUIPC
            use_rd = 1'b1; d_src1 = SRC_PC; d_src2 = SRC_IMM; d_imm = imm_u;
         end
         7'b1101111: begin // JAL
            use_rd = 1'b1; d_src1 = SRC_PC; d_src2 = SRC_IMM; d_imm = imm_j;
            d_jmp  = 1'b1;
         end
         7'b1100111: begin // JALR
            use_rs1 = 1'b1; use_rd = 1'b1; d_src2 = SRC_IMM; d_imm = imm_i;
            d_jmp   = 1'b1;
            bad_enc = (funct3 != 3'b000);
         end
         default: bad_enc = 1'b1;
      endcase

      d_ill = bad_enc
            || (use_rs1 && ({1'b0, rs1_f} >= REG_LIMIT))
            || (use_rs2 && ({1'b0, rs2_f} >= REG_LIMIT))
            || (use_rd  && ({1'b0, rd_f}  >= REG_LIMIT));

      // Illegal instructions read and write no registers, so they can never
      // cause or suffer a load-use hazard.
      d_rs1 = (use_rs1 && !d_ill) ? rs1_f : 5'd0;
      d_rs2 = (use_rs2 && !d_ill) ? rs2_f : 5'd0;
      d_rd  = (use_rd  && !d_ill) ? rd_f  : 5'd0;

      if (d_ill) begin
         d_op   = ALU_ADD;
         d_src1 = SRC_RS1;
         d_src2 = SRC_RS2;
         d_size = UNDEF;
         d_re   = 1'b0;
         d_we   = 1'b0;
         d_br   = 1'b0;
         d_jmp  = 1'b0;
         d_imm  = '0;
         d_cond = '0;
      end
   end

   assign bus.sel_rs1_o = d_rs1;
   assign bus.sel_rs2_o = d_rs2;

   // Unused selects are 0 and sel_rd_o is nonzero here, so a plain index
   // compare only ever matches a register the new instruction really reads.
   logic hazard, accept;
   assign hazard = LOAD_USE_INTERLOCK && bus.out_valid_o && bus.mem_re_o
                && (bus.sel_rd_o != 5'd0) && bus.in_valid_i
                && ((d_rs1 == bus.sel_rd_o) || (d_rs2 == bus.sel_rd_o));
   assign bus.in_ready_o = (!bus.out_valid_o || bus.out_ready_i) && !hazard && !bus.flush_i;
   assign accept = bus.in_valid_i && bus.in_ready_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid_o <= 1'b0;
         bus.pc_o        <= {PC_WIDTH{1'b0}};
         bus.sel_rd_o    <= '0;
         bus.alu_op_o    <= ALU_ADD;
         bus.alu_src1_o  <= SRC_RS1;
         bus.alu_src2_o  <= SRC_RS1;
         bus.mem_re_o    <= 1'b0;
         bus.mem_we_o    <= 1'b0;
         bus.mem_size_o  <= UNDEF;
         bus.imm_o       <= '0;
         bus.branch_o    <= 1'b0;
         bus.br_cond_o   <= '0;
         bus.jump_o      <= 1'b0;
         bus.illegal_o   <= 1'b0;
      end else if (bus.flush_i) begin
         bus.out_valid_o <= 1'b0;
      end else if (accept) begin
         bus.out_valid_o <= 1'b1;
         bus.pc_o        <= bus.pc_i;
         bus.sel_rd_o    <= d_rd;
         bus.alu_op_o    <= d_op;
         bus.alu_src1_o  <= d_src1;
         bus.alu_src2_o  <= d_src2;
         bus.mem_re_o    <= d_re;
         bus.mem_we_o    <= d_we;
         bus.mem_size_o  <= d_size;
         bus.imm_o       <= d_imm;
         bus.branch_o    <= d_br;
         bus.br_cond_o   <= d_cond;
         bus.jump_o      <= d_jmp;
         bus.illegal_o   <= d_ill;
      end else if (bus.out_ready_i) begin
         // Drain: execute took the payload (or the stage was already empty).
         bus.out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe
//
// Bench for decode_pipe. Main instance: RV32I with interlock. Two side
// instances share the same inputs: RV32E (NUM_REGS=16) and RV32I without
// interlock; those are only inspected at directed points where their
// behaviour is known. The main instance is compared every cycle against a
// transaction-level model: exp_q holds the instruction currently owned by
// the stage and ref_decode() derives the payload from the ISA tables.
module tb_decode_pipe;
   import decode_pipe_pkg::*;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      alu_op_e     op;
      alu_src_e    s1, s2;
      logic        re, we;
      data_size_e  sz;
      logic [31:0] imm;
      logic        br;
      logic [2:0]  cond;
      logic        jmp;
      logic        ill;
   } dec_t;

   // ---------------- clock / reset / inputs ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] instr, pc;

   always #5 clk = ~clk;

   decode_pipe_if #(.PC_WIDTH(32)) ifc_m ();
   decode_pipe_if #(.PC_WIDTH(32)) ifc_e ();
   decode_pipe_if #(.PC_WIDTH(32)) ifc_n ();

   assign ifc_m.in_valid_i  = in_valid;
   assign ifc_m.instr_i     = instr;
   assign ifc_m.pc_i        = pc;
   assign ifc_m.flush_i     = flush;
   assign ifc_m.out_ready_i = out_ready;
   assign ifc_e.in_valid_i  = in_valid;
   assign ifc_e.instr_i     = instr;
   assign ifc_e.pc_i        = pc;
   assign ifc_e.flush_i     = flush;
   assign ifc_e.out_ready_i = out_ready;
   assign ifc_n.in_valid_i  = in_valid;
   assign ifc_n.instr_i     = instr;
   assign ifc_n.pc_i        = pc;
   assign ifc_n.flush_i     = flush;
   assign ifc_n.out_ready_i = out_ready;

   decode_pipe #(.PC_WIDTH(32), .NUM_REGS(32), .LOAD_USE_INTERLOCK(1'b1)) u_dut (
      .clk(clk), .rst(rst), .bus(ifc_m));
   decode_pipe #(.PC_WIDTH(32), .NUM_REGS(16), .LOAD_USE_INTERLOCK(1'b1)) u_dut_e (
      .clk(clk), .rst(rst), .bus(ifc_e));
   decode_pipe #(.PC_WIDTH(32), .NUM_REGS(32), .LOAD_USE_INTERLOCK(1'b0)) u_dut_n (
      .clk(clk), .rst(rst), .bus(ifc_n));

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit model_live = 1'b0;
   bit exp_ready  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic dec_t ref_decode(input logic [31:0] ins, input int nregs);
      dec_t d;
      int si, f3, f7;
      bit u1, u2, ud, ok;
      alu_op_e    base_op[8];
      data_size_e sizes[8];
      base_op = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      sizes   = '{BYTE_S, HALF_S, WORD, UNDEF, BYTE_U, HALF_U, UNDEF, UNDEF};
      si = $signed(ins);
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      u1 = 0; u2 = 0; ud = 0; ok = 1;
      d.op = ALU_ADD; d.s1 = SRC_RS1; d.s2 = SRC_RS2; d.re = 0; d.we = 0;
      d.sz = UNDEF; d.imm = 0; d.br = 0; d.cond = 0; d.jmp = 0; d.ill = 0;
      case (ins[6:0])
         7'h33: begin
            u1 = 1; u2 = 1; ud = 1;
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            d.op = base_op[f3];
            if (f7 == 32 && f3 == 0) d.op = ALU_SUB;
            if (f7 == 32 && f3 == 5) d.op = ALU_SRA;
         end
         7'h13: begin
            u1 = 1; ud = 1; d.s2 = SRC_IMM; d.op = base_op[f3];
            if (f3 == 1 || f3 == 5) begin
               d.imm = 32'(ins[24:20]);
               ok = (f7 == 0) || (f3 == 5 && f7 == 32);
               if (f3 == 5 && f7 == 32) d.op = ALU_SRA;
            end else d.imm = si >>> 20;
         end
         7'h03: begin
            u1 = 1; ud = 1; d.s2 = SRC_IMM; d.re = 1; d.imm = si >>> 20;
            d.sz = sizes[f3]; ok = (d.sz != UNDEF);
         end
         7'h23: begin
            u1 = 1; u2 = 1; d.s2 = SRC_IMM; d.we = 1;
            d.imm = ((si >>> 25) <<< 5) | int'(ins[11:7]);
            d.sz = sizes[f3]; ok = (f3 < 3);
         end
         7'h63: begin
            u1 = 1; u2 = 1; d.br = 1; d.cond = ins[14:12];
            d.imm = ((si >>> 31) <<< 12) | (int'(ins[7]) << 11)
                  | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
            ok = !(f3 == 2 || f3 == 3);
            d.op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
         end
         7'h37: begin ud = 1; d.s1 = SRC_ZERO; d.s2 = SRC_IMM; d.imm = ins & 32'hFFFFF000; end
         7'h17: begin ud = 1; d.s1 = SRC_PC;   d.s2 = SRC_IMM; d.imm = ins & 32'hFFFFF000; end
         7'h6F: begin
            ud = 1; d.s1 = SRC_PC; d.s2 = SRC_IMM; d.jmp = 1;
            d.imm = ((si >>> 31) <<< 20) | (int'(ins[19:12]) << 12)
                  | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
         end
         7'h67: begin
            u1 = 1; ud = 1; d.s2 = SRC_IMM; d.jmp = 1; d.imm = si >>> 20; ok = (f3 == 0);
         end
         default: ok = 0;
      endcase
      if (u1 && int'(ins[19:15]) >= nregs) ok = 0;
      if (u2 && int'(ins[24:20]) >= nregs) ok = 0;
      if (ud && int'(ins[11:7])  >= nregs) ok = 0;
      if (!ok) begin
         d.op = ALU_ADD; d.s1 = SRC_RS1; d.s2 = SRC_RS2; d.re = 0; d.we = 0;
         d.sz = UNDEF; d.imm = 0; d.br = 0; d.cond = 0; d.jmp = 0; d.ill = 1;
         u1 = 0; u2 = 0; ud = 0;
      end
      d.rs1 = u1 ? ins[19:15] : 5'd0;
      d.rs2 = u2 ? ins[24:20] : 5'd0;
      d.rd  = ud ? ins[11:7]  : 5'd0;
      return d;
   endfunction

   // Compare the main DUT against the model at the negedge, before the edge
   // that will consume the current inputs.
   task automatic model_check();
      dec_t e, c;
      bit   haz;
      if (!model_live) return;
      chk("out_valid", 32'(ifc_m.out_valid_o), 32'(exp_q.size() != 0));
      c   = ref_decode(instr, 32);
      haz = 1'b0;
      if (exp_q.size() != 0) begin
         e = ref_decode(exp_q[0], 32);
         chk("pc_o",     ifc_m.pc_o, exp_pc_q[0]);
         chk("sel_rd",   32'(ifc_m.sel_rd_o),   32'(e.rd));
         chk("alu_op",   32'(ifc_m.alu_op_o),   32'(e.op));
         chk("alu_src1", 32'(ifc_m.alu_src1_o), 32'(e.s1));
         chk("alu_src2", 32'(ifc_m.alu_src2_o), 32'(e.s2));
         chk("mem_re",   32'(ifc_m.mem_re_o),   32'(e.re));
         chk("mem_we",   32'(ifc_m.mem_we_o),   32'(e.we));
         chk("mem_size", 32'(ifc_m.mem_size_o), 32'(e.sz));
         chk("imm",      ifc_m.imm_o,           e.imm);
         chk("branch",   32'(ifc_m.branch_o),   32'(e.br));
         chk("br_cond",  32'(ifc_m.br_cond_o),  32'(e.cond));
         chk("jump",     32'(ifc_m.jump_o),     32'(e.jmp));
         chk("illegal",  32'(ifc_m.illegal_o),  32'(e.ill));
         haz = e.re && (e.rd != 0) && in_valid && (c.rs1 == e.rd || c.rs2 == e.rd);
      end
      chk("sel_rs1", 32'(ifc_m.sel_rs1_o), 32'(c.rs1));
      chk("sel_rs2", 32'(ifc_m.sel_rs2_o), 32'(c.rs2));
      exp_ready = (exp_q.size() == 0 || out_ready) && !flush && !haz;
      chk("in_ready", 32'(ifc_m.in_ready_o), 32'(exp_ready));
   endtask

   task automatic model_update();
      if (rst) begin
         exp_q.delete(); exp_pc_q.delete(); model_live = 1'b1;
      end else if (!model_live) begin
         // nothing known before the first reset
      end else if (flush) begin
         exp_q.delete(); exp_pc_q.delete();
      end else if (in_valid && exp_ready) begin
         exp_q.delete(); exp_pc_q.delete();
         exp_q.push_back(instr); exp_pc_q.push_back(pc);
      end else if (out_ready) begin
         exp_q.delete(); exp_pc_q.delete();
      end
   endtask

   // One clock: check at negedge, advance model at posedge, settle 1 unit.
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  ops[9];
      logic [6:0]  op;
      int k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k == 9) return r;
      op = (k == 10) ? 7'h03 : (k == 11) ? 7'h33 : ops[k];
      r[6:0] = op;
      if ($urandom_range(0, 15) != 0) begin
         r[19:15] = 5'($urandom_range(0, 5));
         r[24:20] = 5'($urandom_range(0, 5));
         r[11:7]  = 5'($urandom_range(0, 5));
      end
      if (op == 7'h33 || op == 7'h13) begin
         case ($urandom_range(0, 3))
            0, 1:    r[31:25] = 7'h00;
            2:       r[31:25] = 7'h20;
            default: ;
         endcase
      end
      if (op == 7'h67 && $urandom_range(0, 3) != 0) r[14:12] = 3'b000;
      return r;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      instr = 32'h0; pc = 32'h0;
      step();
      rst = 1'b0;
      chk("rst_valid",    32'(ifc_m.out_valid_o), 32'd0);
      chk("rst_pc",       ifc_m.pc_o,             32'd0);
      chk("rst_sel_rd",   32'(ifc_m.sel_rd_o),    32'd0);
      chk("rst_imm",      ifc_m.imm_o,            32'd0);
      chk("rst_mem_size", 32'(ifc_m.mem_size_o),  32'(UNDEF));
      chk("rst_illegal",  32'(ifc_m.illegal_o),   32'd0);

      // ADDI x5,x1,-3
      in_valid = 1'b1; instr = 32'hFFD08293; pc = 32'h100; out_ready = 1'b1;
      #1;
      chk("t1_sel_rs1", 32'(ifc_m.sel_rs1_o), 32'd1);
      chk("t1_in_ready", 32'(ifc_m.in_ready_o), 32'd1);
      step();
      chk("t1_valid", 32'(ifc_m.out_valid_o), 32'd1);
      chk("t1_rd",    32'(ifc_m.sel_rd_o),    32'd5);
      chk("t1_op",    32'(ifc_m.alu_op_o),    32'(ALU_ADD));
      chk("t1_src2",  32'(ifc_m.alu_src2_o),  32'(SRC_IMM));
      chk("t1_imm",   ifc_m.imm_o,            32'hFFFFFFFD);

      // Stall 3 cycles with ADD waiting at the input, then release.
      instr = 32'h00118233; pc = 32'h104; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t2_in_ready_stall", 32'(ifc_m.in_ready_o), 32'd0);
         step();
         chk("t2_hold_rd",  32'(ifc_m.sel_rd_o), 32'd5);
         chk("t2_hold_imm", ifc_m.imm_o,         32'hFFFFFFFD);
      end
      out_ready = 1'b1;
      #1;
      chk("t2_in_ready_release", 32'(ifc_m.in_ready_o), 32'd1);
      step();
      chk("t2_next_rd", 32'(ifc_m.sel_rd_o), 32'd4);
      chk("t2_next_pc", ifc_m.pc_o,          32'h104);

      // LW x3,0(x2) then ADD x4,x3,x1: one bubble with interlock, none without.
      instr = 32'h00012183; pc = 32'h200;
      step();
      chk("t3_lw_re",   32'(ifc_m.mem_re_o),   32'd1);
      chk("t3_lw_rd",   32'(ifc_m.sel_rd_o),   32'd3);
      chk("t3_lw_size", 32'(ifc_m.mem_size_o), 32'(WORD));
      instr = 32'h00118233; pc = 32'h204;
      #1;
      chk("t3_hazard_ready",    32'(ifc_m.in_ready_o), 32'd0);
      chk("t3_noil_ready",      32'(ifc_n.in_ready_o), 32'd1);
      step();
      chk("t3_bubble",          32'(ifc_m.out_valid_o), 32'd0);
      chk("t3_noil_valid",      32'(ifc_n.out_valid_o), 32'd1);
      chk("t3_noil_rd",         32'(ifc_n.sel_rd_o),    32'd4);
      #1;
      chk("t3_after_bubble_ready", 32'(ifc_m.in_ready_o), 32'd1);
      step();
      chk("t3_add_valid", 32'(ifc_m.out_valid_o), 32'd1);
      chk("t3_add_rd",    32'(ifc_m.sel_rd_o),    32'd4);

      // BLT x1,x2,-8
      instr = 32'hFE20CCE3; pc = 32'h300;
      step();
      chk("t4_branch", 32'(ifc_m.branch_o),  32'd1);
      chk("t4_cond",   32'(ifc_m.br_cond_o), 32'd4);
      chk("t4_op",     32'(ifc_m.alu_op_o),  32'(ALU_SLT));
      chk("t4_imm",    ifc_m.imm_o,          32'hFFFFFFF8);
      chk("t4_rd",     32'(ifc_m.sel_rd_o),  32'd0);

      // Flush alongside a valid input.
      instr = 32'hFFD08293; pc = 32'h304; flush = 1'b1;
      #1;
      chk("t5_flush_ready", 32'(ifc_m.in_ready_o), 32'd0);
      step();
      chk("t5_flush_valid", 32'(ifc_m.out_valid_o), 32'd0);
      flush = 1'b0;

      // Reset in the middle of a stall.
      instr = 32'h00012183; pc = 32'h400; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      chk("t5_stalled_valid", 32'(ifc_m.out_valid_o), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_rst_valid", 32'(ifc_m.out_valid_o), 32'd0);
      chk("t5_rst_re",    32'(ifc_m.mem_re_o),    32'd0);
      chk("t5_rst_rd",    32'(ifc_m.sel_rd_o),    32'd0);
      chk("t5_rst_pc",    ifc_m.pc_o,             32'd0);
      chk("t5_rst_size",  32'(ifc_m.mem_size_o),  32'(UNDEF));

      // ADDI x17,x0,1: legal on RV32I, illegal on RV32E. Then opcode 0.
      in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00100893; pc = 32'h500;
      step();
      chk("t6_e_valid",   32'(ifc_e.out_valid_o), 32'd1);
      chk("t6_e_illegal", 32'(ifc_e.illegal_o),   32'd1);
      chk("t6_e_rd",      32'(ifc_e.sel_rd_o),    32'd0);
      chk("t6_i_illegal", 32'(ifc_m.illegal_o),   32'd0);
      chk("t6_i_rd",      32'(ifc_m.sel_rd_o),    32'd17);
      instr = 32'h00000000; pc = 32'h504;
      step();
      chk("t6_zero_valid",   32'(ifc_m.out_valid_o), 32'd1);
      chk("t6_zero_illegal", 32'(ifc_m.illegal_o),   32'd1);
      chk("t6_zero_imm",     ifc_m.imm_o,            32'd0);
      in_valid = 1'b0;
      step();

      // Randomised traffic, checked every cycle by the model.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         instr     = gen_instr();
         pc        = $urandom & 32'hFFFFFFFC;
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Parametrised successor of the ID stage: full RV32I/RV32E decode with a valid/ready handshake in place of a bare stall. Adds load-use interlock, flush, PC carry-through and illegal-instruction flagging. Sits between fetch (upstream valid/ready) and execute (downstream valid/ready). Register-file read selects are combinational; all control outputs are registered.

Parameters:
PC_WIDTH, 32, width of pc_i/pc_o
NUM_REGS, 32, architectural register count (32 = RV32I, 16 = RV32E); any rs1/rs2/rd index >= NUM_REGS is illegal
LOAD_USE_INTERLOCK, 1, 1 = insert one bubble on a load-use hazard; 0 = no interlock (execute forwards)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
in_valid_i  in  1  instr_i/pc_i valid
in_ready_o  out  1  stage accepts input this cycle
instr_i  in  32  instruction
pc_i  in  PC_WIDTH  instruction address
flush_i  in  1  kill the stage contents (branch mispredict/redirect)
out_ready_i  in  1  execute accepts output
out_valid_o  out  1  output payload valid
pc_o  out  PC_WIDTH  registered pc
sel_rs1_o  out  5  combinational rs1 index; 0 if unused
sel_rs2_o  out  5  combinational rs2 index; 0 if unused
sel_rd_o  out  5  dest index; 0 if no writeback
alu_op_o  out  alu_op_e  ALU op
alu_src1_o  out  alu_src_e  RS1, PC or ZERO
alu_src2_o  out  alu_src_e  RS2 or IMM
mem_re_o  out  1  load
mem_we_o  out  1  store
mem_size_o  out  data_size_e  BYTE_S/BYTE_U/HALF_S/HALF_U/WORD/UNDEF
imm_o  out  32  sign-extended immediate
branch_o  out  1  conditional branch
br_cond_o  out  3  funct3 of branch; 0 otherwise
jump_o  out  1  JAL/JALR; execute writes pc_o+4 to rd
illegal_o  out  1  illegal instruction

Behaviour:
- Reset (rst high at a posedge): all registered outputs 0, mem_size_o UNDEF. Reset overrides flush, handshake and any in-flight instruction.
- Latency: 1 cycle from acceptance to out_valid_o.
- Hazard (only when LOAD_USE_INTERLOCK=1): out_valid_o & mem_re_o & sel_rd_o!=0 & in_valid_i & a used rs of instr_i equals sel_rd_o.
- in_ready_o = (!out_valid_o | out_ready_i) & !hazard & !flush_i.
- Accept (in_valid_i & in_ready_o): the output register loads the decoded payload and out_valid_o becomes 1.
- Drain without accept (out_ready_i & out_valid_o & no accept): out_valid_o becomes 0. On a hazard with out_ready_i high this is exactly one bubble; the dependent instruction is accepted the following cycle.
- Stall (out_valid_o & !out_ready_i): all outputs hold.
- flush_i: highest priority after rst. out_valid_o becomes 0 next cycle and nothing is accepted. Payload fields may hold stale values but are don't-care while out_valid_o=0.
- Decode by opcode:
  - R-type: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - OP-IMM: I-imm; SLLI/SRLI/SRAI use shamt and must have legal funct7.
  - LOAD: ALU_ADD RS1+IMM, mem_size per funct3.
  - STORE: S-imm, sel_rd 0.
  - BRANCH: B-imm. ALU_SUB for BEQ/BNE, ALU_SLT for BLT/BGE, ALU_SLTU for BLTU/BGEU.
  - LUI: ZERO+IMM, U-imm = instr[31:12]<<12.
  - AUIPC: PC+IMM.
  - JAL: PC+IMM, J-imm, jump_o.
  - JALR: RS1+IMM, jump_o; funct3 must be 0.
- rd = x0 on a writeback instruction: sel_rd_o = 0, instruction otherwise legal.
- Illegal: unknown opcode/funct3/funct7, or any used register index >= NUM_REGS.
  - Sets illegal_o=1 and sel_rd/mem_re/mem_we/branch/jump = 0, imm = 0.
  - Still handshakes as a normal instruction.
- Unused rs selects are 0 and never trigger a hazard.

Test Plan:
1. ADDI x5,x1,-3 (0xFFD08293), out_ready_i=1 -> next cycle out_valid_o=1, sel_rd_o=5, alu_op_o=ALU_ADD, alu_src2_o=IMM, imm_o=0xFFFFFFFD, sel_rs1_o=1 combinationally.
2. out_ready_i=0 for 3 cycles with a valid instruction registered -> outputs stable, in_ready_o=0; release -> next instruction appears the cycle after.
3. LW x3,0(x2) (0x00012183) then ADD x4,x3,x1 (0x00118233), out_ready_i=1 -> LW valid, then exactly one out_valid_o=0 cycle, then ADD with sel_rd_o=4. With LOAD_USE_INTERLOCK=0 -> no bubble.
4. BLT x1,x2,-8 (0xFE20CCE3) -> branch_o=1, br_cond_o=3'b100, alu_op_o=ALU_SLT, imm_o=0xFFFFFFF8, sel_rd_o=0.
5. flush_i asserted in the same cycle as a valid input -> in_ready_o=0, out_valid_o=0 next cycle. rst pulsed mid-stall -> all outputs 0 next cycle.
6. NUM_REGS=16, ADDI x17,x0,1 (0x00100893) -> illegal_o=1, sel_rd_o=0, out_valid_o=1. Opcode 0x00000000 -> illegal_o=1.
